pipeline_hazard_ctrl: RTL

Central sequencer for the 5-stage CPU pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC. It generates per-stage enables and flushes, EX-stage operand forwarding selects, and the data-memory request handshake. It detects load-use hazards, applies taken-branch flushes, and freezes the pipe while data memory is busy. A wait timeout raises a sticky fault.

---
 rtl/pipeline_ctrl_pkg.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// sequencer states, stage bit map, forwarding codes and a freeze helper.
package pipeline_ctrl_pkg;

   localparam int REG_W      = 6;
   localparam int NUM_STG    = 5;

   localparam int STG_PC     = 0;
   localparam int STG_IF_ID  = 1;
   localparam int STG_ID_EX  = 2;
   localparam int STG_EX_MEM = 3;
   localparam int STG_MEM_WB = 4;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   typedef struct packed {
      logic [NUM_STG-1:0] en;
      logic [NUM_STG-1:0] flush;
      logic               pc_sel;
   } stage_ctrl_t;

   // Whole pipe held; a bubble enters MEM_WB so WB does not retire twice.
   function automatic stage_ctrl_t freeze_ctrl();
      stage_ctrl_t c;
      c.en             = {NUM_STG{1'b0}};
      c.flush          = {NUM_STG{1'b0}};
      c.flush[STG_MEM_WB] = 1'b1;
      c.pc_sel         = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// EX-stage operand forwarding select for one source register.
// MEM has priority over WB; register 0 is never forwarded.
module fwd_select
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] ex_src,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_reg_write,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_reg_write,
   output logic [1:0]       fwd_sel
);

   logic mem_hit_s;
   logic wb_hit_s;

   always_comb begin
      mem_hit_s = mem_reg_write && (mem_rd != {REG_W{1'b0}}) && (mem_rd == ex_src);
      wb_hit_s  = wb_reg_write  && (wb_rd  != {REG_W{1'b0}}) && (wb_rd  == ex_src);
      if (mem_hit_s) begin
         fwd_sel = FWD_MEM;
      end else if (wb_hit_s) begin
         fwd_sel = FWD_WB;
      end else begin
         fwd_sel = FWD_RF;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC select, forwarding selects,
// data-memory handshake with wait timeout, and a saturating stall counter.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
)
(
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [REG_W-1:0]   ID_Rs,
   input  logic [REG_W-1:0]   ID_Rt,
   input  logic [REG_W-1:0]   EX_Rs,
   input  logic [REG_W-1:0]   EX_Rt,
   input  logic [REG_W-1:0]   EX_Rd,
   input  logic               EX_MemRead,
   input  logic [REG_W-1:0]   MEM_Rd,
   input  logic               MEM_RegWrite,
   input  logic               MEM_MemAccess,
   input  logic               MEM_BranchTaken,
   input  logic [REG_W-1:0]   WB_Rd,
   input  logic               WB_RegWrite,
   input  logic               DMEM_ACK,
   output logic               DMEM_REQ,
   output logic [NUM_STG-1:0] STAGE_EN,
   output logic [NUM_STG-1:0] STAGE_FLUSH,
   output logic               PC_SEL,
   output logic [1:0]         ForwardA,
   output logic [1:0]         ForwardB,
   output logic               MEM_FAULT,
   output logic [CNT_W-1:0]   STALL_CNT
);

   localparam int WCNT_W = $clog2(WAIT_MAX + 1);

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic                load_use_s;
   stage_ctrl_t         norm_s;
   stage_ctrl_t         ctrl_s;
   logic                req_s;
   logic [1:0]          fwd_a_s;
   logic [1:0]          fwd_b_s;

   fwd_select u_fwd_a (
      .ex_src        (EX_Rs),
      .mem_rd        (MEM_Rd),
      .mem_reg_write (MEM_RegWrite),
      .wb_rd         (WB_Rd),
      .wb_reg_write  (WB_RegWrite),
      .fwd_sel       (fwd_a_s)
   );

   fwd_select u_fwd_b (
      .ex_src        (EX_Rt),
      .mem_rd        (MEM_Rd),
      .mem_reg_write (MEM_RegWrite),
      .wb_rd         (WB_Rd),
      .wb_reg_write  (WB_RegWrite),
      .fwd_sel       (fwd_b_s)
   );

   // Normal-flow control: taken branch beats load-use, which inserts one bubble.
   always_comb begin
      load_use_s   = EX_MemRead && (EX_Rd != {REG_W{1'b0}}) &&
                     ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));
      norm_s.en     = {NUM_STG{1'b1}};
      norm_s.flush  = {NUM_STG{1'b0}};
      norm_s.pc_sel = 1'b0;
      if (MEM_BranchTaken) begin
         norm_s.pc_sel            = 1'b1;
         norm_s.flush[STG_IF_ID]  = 1'b1;
         norm_s.flush[STG_ID_EX]  = 1'b1;
         norm_s.flush[STG_EX_MEM] = 1'b1;
      end else if (load_use_s) begin
         norm_s.en[STG_PC]        = 1'b0;
         norm_s.en[STG_IF_ID]     = 1'b0;
         norm_s.flush[STG_ID_EX]  = 1'b1;
      end else begin
         norm_s.pc_sel = 1'b0;
      end
   end

   // Sequencer next state and Mealy stage controls.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      ctrl_s     = norm_s;
      req_s      = 1'b0;
      case (state_q)
         RUN: begin
            req_s = MEM_MemAccess;
            if (MEM_MemAccess && !DMEM_ACK) begin
               ctrl_s     = freeze_ctrl();
               state_d    = MEM_WAIT;
               wait_cnt_d = WCNT_W'(1);
            end else begin
               ctrl_s = norm_s;
            end
         end
         MEM_WAIT: begin
            req_s = 1'b1;
            if (DMEM_ACK) begin
               state_d    = RUN;
               wait_cnt_d = {WCNT_W{1'b0}};
            end else if (wait_cnt_q == WCNT_W'(WAIT_MAX)) begin
               ctrl_s  = freeze_ctrl();
               state_d = FAULT;
            end else begin
               ctrl_s     = freeze_ctrl();
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         FAULT: begin
            ctrl_s.en     = {NUM_STG{1'b0}};
            ctrl_s.flush  = {NUM_STG{1'b0}};
            ctrl_s.pc_sel = 1'b0;
         end
         default: begin
            ctrl_s     = freeze_ctrl();
            state_d    = RUN;
            wait_cnt_d = {WCNT_W{1'b0}};
         end
      endcase
   end

   // Saturating count of cycles with the PC held, excluding the fault state.
   always_comb begin
      if (!ctrl_s.en[STG_PC] && (state_q != FAULT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Sequencer state and counters.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= RUN;
         wait_cnt_q  <= {WCNT_W{1'b0}};
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Outputs are forced to their reset values for the whole time reset is low.
   always_comb begin
      if (!RESET_N) begin
         STAGE_EN    = {NUM_STG{1'b0}};
         STAGE_FLUSH = 5'b11110;
         DMEM_REQ    = 1'b0;
         PC_SEL      = 1'b0;
         ForwardA    = FWD_RF;
         ForwardB    = FWD_RF;
         MEM_FAULT   = 1'b0;
      end else begin
         STAGE_EN    = ctrl_s.en;
         STAGE_FLUSH = ctrl_s.flush;
         DMEM_REQ    = req_s;
         PC_SEL      = ctrl_s.pc_sel;
         ForwardA    = fwd_a_s;
         ForwardB    = fwd_b_s;
         MEM_FAULT   = (state_q == FAULT);
      end
   end

   assign STALL_CNT = stall_cnt_q;

endmodule
